// File: rtl/right_shift_deser_pkg.sv
// Shared types for the LSB-first serial deserializer.
// Optional feature macro: DESER_PARITY_EN (adds a trailing even-parity bit).
package right_shift_deser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef DESER_PARITY_EN
    ,PARITY = 2'd2
`endif
  } deser_state_t;

  localparam int DEFAULT_DW = 4;

  // Bit counter must be able to hold the value DW itself.
  function automatic int cnt_width(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/right_shift_deser_if.sv
// Serial input / parallel output bundle for right_shift_deser.
// master: the deserializer side; slave: link driver plus consumer side.
interface right_shift_deser_if #(
  parameter int DW = 4
);
  logic          en;
  logic          start;
  logic          din;
  logic [DW-1:0] q;
  logic          q_valid;
  logic          q_ready;
  logic          q_perr;
  logic          overrun;
  logic          clr_err;
  logic          busy;

  modport master (
    input  en, start, din, q_ready, clr_err,
    output q, q_valid, q_perr, overrun, busy
  );

  modport slave (
    output en, start, din, q_ready, clr_err,
    input  q, q_valid, q_perr, overrun, busy
  );
endinterface

// File: rtl/right_shift_deser_bit_counter.sv
// Loadable up-counter of accepted bits within a frame.
// 'last' flags that the next accepted bit is the DW-th data bit.
module deser_bit_counter #(
  parameter int DW = 4,
  parameter int CW = 3
) (
  input  logic clk,
  input  logic sync_rst_n,
  input  logic clr,
  input  logic load,
  input  logic inc,
  output logic last
);
  logic [CW-1:0] cnt_reg;

  // Clear on frame end, load 1 on a start bit, otherwise count accepted bits.
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= CW'(1);
    end else if (inc) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign last = (cnt_reg == CW'(DW - 1));
endmodule

// File: rtl/right_shift_deser.sv
// LSB-first serial-to-parallel receiver with valid/ready output and sticky overrun.
// Optional feature macro: DESER_PARITY_EN (one even-parity bit after the data bits).
module right_shift_deser
  import right_shift_deser_pkg::*;
#(
  parameter int DW = DEFAULT_DW
) (
  input  logic               clk,
  input  logic               sync_rst_n,
  right_shift_deser_if.master bus
);
  localparam int CW = cnt_width(DW);

  deser_state_t  state_reg, state_next;
  logic [DW-1:0] sreg_reg;
  logic [DW-1:0] q_reg;
  logic          q_valid_reg;
  logic          overrun_reg;
  logic          busy_reg;
  logic [DW-1:0] cand;
  logic          last;

  // Control strobes decoded from state and the incoming bit.
  logic restart;
  logic shift;
  logic cnt_inc;
  logic complete;
`ifdef DESER_PARITY_EN
  logic from_sreg;
  logic perr_reg;
`endif

  deser_bit_counter #(.DW(DW), .CW(CW)) u_cnt (
    .clk        (clk),
    .sync_rst_n (sync_rst_n),
    .clr        (complete),
    .load       (restart),
    .inc        (cnt_inc),
    .last       (last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!sync_rst_n) state_reg <= IDLE;
    else             state_reg <= state_next;
  end

  // Next-state: a start bit always (re)opens a frame, aborting any partial one.
  always_comb begin
    state_next = state_reg;
    if (bus.en) begin
      case (state_reg)
        IDLE:  if (bus.start) state_next = SHIFT;
        SHIFT: begin
          if (bus.start) state_next = SHIFT;
`ifdef DESER_PARITY_EN
          else if (last) state_next = PARITY;
`else
          else if (last) state_next = IDLE;
`endif
        end
`ifdef DESER_PARITY_EN
        PARITY: state_next = bus.start ? SHIFT : IDLE;
`endif
        default: state_next = IDLE;
      endcase
    end
  end

  // Output decode: per-bit control strobes for datapath and counter.
  always_comb begin
    restart  = 1'b0;
    shift    = 1'b0;
    cnt_inc  = 1'b0;
    complete = 1'b0;
`ifdef DESER_PARITY_EN
    from_sreg = 1'b0;
`endif
    if (bus.en) begin
      case (state_reg)
        IDLE:  restart = bus.start;
        SHIFT: begin
          if (bus.start) begin
            restart = 1'b1;
          end else begin
            shift = 1'b1;
`ifdef DESER_PARITY_EN
            cnt_inc = 1'b1;
`else
            if (last) complete = 1'b1;
            else      cnt_inc  = 1'b1;
`endif
          end
        end
`ifdef DESER_PARITY_EN
        PARITY: begin
          if (bus.start) begin
            restart = 1'b1;
          end else begin
            complete  = 1'b1;
            from_sreg = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef DESER_PARITY_EN
  assign cand = from_sreg ? sreg_reg : {bus.din, sreg_reg[DW-1:1]};
`else
  assign cand = {bus.din, sreg_reg[DW-1:1]};
`endif

  // Datapath: shift register, output word/flags, sticky overrun, busy.
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      sreg_reg    <= '0;
      q_reg       <= '0;
      q_valid_reg <= 1'b0;
      overrun_reg <= 1'b0;
      busy_reg    <= 1'b0;
`ifdef DESER_PARITY_EN
      perr_reg    <= 1'b0;
`endif
    end else begin
      // A start bit discards stale bits so the partial frame leaves no trace.
      if (restart)    sreg_reg <= {bus.din, {(DW-1){1'b0}}};
      else if (shift) sreg_reg <= {bus.din, sreg_reg[DW-1:1]};

      if (complete) begin
        if (!q_valid_reg || bus.q_ready) begin
          q_reg       <= cand;
          q_valid_reg <= 1'b1;
`ifdef DESER_PARITY_EN
          perr_reg    <= ^{sreg_reg, bus.din};
`endif
        end
      end else if (q_valid_reg && bus.q_ready) begin
        q_valid_reg <= 1'b0;
      end

      // A fresh drop outranks a same-cycle clear.
      if (complete && q_valid_reg && !bus.q_ready) overrun_reg <= 1'b1;
      else if (bus.clr_err)                        overrun_reg <= 1'b0;

      busy_reg <= (state_next != IDLE);
    end
  end

  assign bus.q       = q_reg;
  assign bus.q_valid = q_valid_reg;
  assign bus.overrun = overrun_reg;
  assign bus.busy    = busy_reg;
`ifdef DESER_PARITY_EN
  assign bus.q_perr  = perr_reg;
`else
  assign bus.q_perr  = 1'b0;
`endif
endmodule

// File: tb/tb_right_shift_deser.sv
// Bench for right_shift_deser: frame-level reference model plus directed and random stimulus.
module tb_right_shift_deser;
  localparam int DW = 4;
`ifdef DESER_PARITY_EN
  localparam int NB = DW + 1;
`else
  localparam int NB = DW;
`endif

  logic clk = 1'b0;
  logic sync_rst_n = 1'b0;
  bit   chk_on = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  right_shift_deser_if #(.DW(DW)) bus();

  right_shift_deser #(.DW(DW)) dut (
    .clk        (clk),
    .sync_rst_n (sync_rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collect accepted bits of the open frame in a list and
  // assemble the word arithmetically once NB bits are present.
  bit            m_act;
  int            m_bits[$];
  logic [DW-1:0] m_q;
  bit            m_valid, m_perr, m_ovr;
  bit            m_done;
  logic [DW-1:0] m_word;
  bit            m_par;

  initial begin
    m_act = 0; m_q = '0; m_valid = 0; m_perr = 0; m_ovr = 0;
  end

  // Model advances on every clock edge using the inputs presented to the DUT.
  always @(posedge clk) begin
    if (!sync_rst_n) begin
      m_act = 0; m_bits.delete(); m_q = '0; m_valid = 0; m_perr = 0; m_ovr = 0;
    end else begin
      m_done = 0;
      if (bus.en) begin
        if (bus.start) begin
          m_bits.delete();
          m_bits.push_back(int'(bus.din));
          m_act = 1;
        end else if (m_act) begin
          m_bits.push_back(int'(bus.din));
        end
        if (m_act && m_bits.size() == NB) begin
          m_done = 1;
          m_word = '0;
          m_par  = 0;
          foreach (m_bits[i]) begin
            if (i < DW) m_word[i] = m_bits[i][0];
            m_par ^= m_bits[i][0];
          end
          m_bits.delete();
          m_act = 0;
        end
      end
      if (bus.clr_err) m_ovr = 0;
      if (m_done) begin
        if (!m_valid || bus.q_ready) begin
          m_q = m_word;
          m_valid = 1;
`ifdef DESER_PARITY_EN
          m_perr = m_par;
`endif
        end else begin
          m_ovr = 1;
        end
      end else if (m_valid && bus.q_ready) begin
        m_valid = 0;
      end
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("q",       32'(bus.q),  32'(m_q));
      chk("q_valid", 32'(bus.q_valid), 32'(m_valid));
      chk("q_perr",  32'(bus.q_perr),  32'(m_perr));
      chk("overrun", 32'(bus.overrun), 32'(m_ovr));
      chk("busy",    32'(bus.busy),    32'(m_act));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bitx(input bit b, input bit st);
    bus.en = 1'b1; bus.start = st; bus.din = b;
    cyc();
    bus.en = 1'b0; bus.start = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] w, input int gap, input bit flip);
    for (int i = 0; i < DW; i++) begin
      bitx(w[i], i == 0);
      if (i == 1) repeat (gap) cyc();
    end
`ifdef DESER_PARITY_EN
    bitx((^w) ^ flip, 1'b0);
`endif
  endtask

  initial begin
    bus.en = 0; bus.start = 0; bus.din = 0; bus.q_ready = 0; bus.clr_err = 0;
    sync_rst_n = 1'b0;
    cyc();
    chk_on = 1'b1;
    cyc();
    sync_rst_n = 1'b1;

    // Strobes without start are ignored from idle.
    bus.en = 1; bus.start = 0; bus.din = 1;
    repeat (4) cyc();
    bus.en = 0;
    chk("idle_valid", 32'(bus.q_valid), 32'd0);
    chk("idle_busy",  32'(bus.busy),    32'd0);

    // Basic receive.
    bus.q_ready = 1;
    send_word(4'b1011, 0, 1'b0);
    chk("basic_q",     32'(bus.q),       32'hB);
    chk("basic_valid", 32'(bus.q_valid), 32'd1);
    chk("model_pin_b", 32'(m_q),         32'hB);
    cyc();
    chk("basic_taken", 32'(bus.q_valid), 32'd0);

    // Gapped strobe.
    send_word(4'b1011, 3, 1'b0);
    chk("gap_q",     32'(bus.q),       32'hB);
    chk("gap_valid", 32'(bus.q_valid), 32'd1);

    // Overrun while consumer stalls.
    cyc();
    bus.q_ready = 0;
    send_word(4'hA, 0, 1'b0);
    send_word(4'h5, 0, 1'b0);
    chk("ovr_q",    32'(bus.q),       32'hA);
    chk("ovr_flag", 32'(bus.overrun), 32'd1);
    bus.clr_err = 1; cyc(); bus.clr_err = 0;
    chk("ovr_clr",  32'(bus.overrun), 32'd0);
    bus.q_ready = 1; cyc();
    chk("ovr_drain", 32'(bus.q_valid), 32'd0);

    // Abort and restart.
    bitx(1'b1, 1'b1);
    bitx(1'b0, 1'b0);
    send_word(4'h6, 0, 1'b0);
    chk("abort_q",   32'(bus.q), 32'h6);
    chk("model_pin_6", 32'(m_q), 32'h6);

    // Reset mid-frame.
    bitx(1'b1, 1'b1);
    bitx(1'b1, 1'b0);
    sync_rst_n = 0; cyc(); sync_rst_n = 1;
    chk("rst_q",    32'(bus.q),    32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    send_word(4'h9, 0, 1'b0);
    chk("rst_next_q", 32'(bus.q), 32'h9);

`ifdef DESER_PARITY_EN
    send_word(4'b1011, 0, 1'b0);
    chk("par_ok",   32'(bus.q_perr), 32'd0);
    send_word(4'b1011, 0, 1'b1);
    chk("par_bad",  32'(bus.q_perr), 32'd1);
    chk("par_q",    32'(bus.q),      32'hB);
`endif

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      sync_rst_n  = ($urandom_range(0, 299) != 0);
      bus.en      = $urandom_range(0, 1);
      bus.start   = ($urandom_range(0, 7) == 0);
      bus.din     = $urandom_range(0, 1);
      bus.q_ready = $urandom_range(0, 1);
      bus.clr_err = ($urandom_range(0, 15) == 0);
      cyc();
    end
    sync_rst_n = 1; bus.en = 0; bus.start = 0; bus.clr_err = 0; bus.q_ready = 1;
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
